// File: rtl/tx_fifo_serializer.sv
// TX FIFO read side: pops one 32-bit word at a time and hands it to the LED
// modulator as four bytes, MSB first, over a valid/ready byte handshake.
module tx_fifo_serializer #(
  parameter int FIFO_RD_LATENCY = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [31:0]          fifo_dout,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 word_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent
);

  // state | meaning
  // IDLE  | waiting for enable with a non-empty FIFO
  // READ  | one-cycle fifo_rd_en pop strobe
  // WAIT  | FIFO read latency; the last cycle captures fifo_dout
  // SEND  | four bytes presented to the modulator
  typedef enum logic [1:0] {IDLE, READ, WAIT, SEND} state_t;

  localparam logic [1:0]           LAT_LOAD = 2'(FIFO_RD_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [31:0]          shift_q, shift_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           lat_q, lat_d;
  logic [7:0]           byte_out_q, byte_out_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 byte_last_q, byte_last_d;
  logic                 word_done_q, word_done_d;
  logic                 fifo_rd_en_q, fifo_rd_en_d;
  logic [CNT_WIDTH-1:0] words_sent_q, words_sent_d;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      lat_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      word_done_q  <= 1'b0;
      fifo_rd_en_q <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      word_done_q  <= word_done_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    word_done_d  = 1'b0;
    fifo_rd_en_d = 1'b0;
    words_sent_d = words_sent_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d      = READ;
          fifo_rd_en_d = 1'b1;
        end
      end
      READ: begin
        state_d = WAIT;
        lat_d   = LAT_LOAD;
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          shift_d      = fifo_dout;
          byte_out_d   = fifo_dout[31:24];
          byte_valid_d = 1'b1;
          byte_last_d  = 1'b0;
          idx_d        = 2'd0;
          state_d      = SEND;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      SEND: begin
        if (byte_valid_q && byte_ready) begin
          if (idx_q == 2'd3) begin
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            word_done_d  = 1'b1;
            words_sent_d = words_sent_q + CNT_ONE;
            idx_d        = 2'd0;
            state_d      = IDLE;
          end else begin
            // shift_q still holds the presented byte in [31:24]; the next one sits below it
            byte_out_d  = shift_q[23:16];
            shift_d     = {shift_q[23:0], 8'h00};
            idx_d       = idx_q + 2'd1;
            byte_last_d = (idx_q == 2'd2);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign word_done  = word_done_q;
  assign words_sent = words_sent_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tx_fifo_serializer.sv
// Bench for tx_fifo_serializer: FIFO model plus byte scoreboard, a table of
// single-word vectors and hand-written multi-cycle sequences.
module tb_tx_fifo_serializer;
  localparam int L  = 1;
  localparam int CW = 4;

  logic          s_axi_aclk = 1'b0;
  logic          s_axi_aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          byte_ready = 1'b0;
  logic          fifo_empty;
  logic [31:0]   fifo_dout = 32'h0;
  logic          fifo_rd_en, byte_valid, byte_last, word_done, busy;
  logic [7:0]    byte_out;
  logic [CW-1:0] words_sent;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   fifo_q[$];
  logic [8:0]    exp_q[$];
  logic [CW-1:0] exp_ws = '0;

  int   cyc = 0;
  int   last_rd = -100;
  int   prev_rd = -100;
  int   rd_total = 0;
  int   done_cnt = 0;
  int   accept_cnt = 0;
  logic pend_done = 1'b0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_byte = 8'h0;

  tx_fifo_serializer #(.FIFO_RD_LATENCY(L), .CNT_WIDTH(CW)) dut (
    .s_axi_aclk(s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_last(byte_last),
    .word_done(word_done),
    .busy(busy),
    .words_sent(words_sent)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  assign fifo_empty = (fifo_q.size() == 0);

  // One-cycle read latency FIFO model
  always @(posedge s_axi_aclk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
      else fifo_dout <= 32'hBAD0_BAD0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back({1'b0, w[31:24]});
    exp_q.push_back({1'b0, w[23:16]});
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge s_axi_aclk);
      #1;
    end
  endtask

  task automatic wait_words(input int n, input logic [7:0] pat, input int budget, input string nm);
    int target;
    int k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin
      byte_ready = pat[k % 8];
      tick(1);
      k++;
    end
    n_vec++;
    if (done_cnt < target) begin
      n_err++;
      $display("FAIL %s timeout: words done %0d, needed %0d", nm, done_cnt, target);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge
  always @(negedge s_axi_aclk) begin
    cyc++;
    if (!s_axi_aresetn) begin
      prev_valid = 1'b0;
      pend_done  = 1'b0;
    end else begin
      if (pend_done || word_done) begin
        n_vec++;
        if (word_done !== pend_done) begin
          n_err++;
          $display("FAIL word_done: got %b expected %b", word_done, pend_done);
        end
      end
      if (word_done) begin
        done_cnt++;
        exp_ws = exp_ws + 1'b1;
        n_vec++;
        if (words_sent !== exp_ws) begin
          n_err++;
          $display("FAIL words_sent_model: got %h expected %h", words_sent, exp_ws);
        end
      end
      pend_done = 1'b0;
      if (fifo_rd_en) begin
        n_vec++;
        if (fifo_empty || word_done) begin
          n_err++;
          $display("FAIL rd_en_legal: empty=%b word_done=%b expected both 0", fifo_empty, word_done);
        end
        prev_rd = last_rd;
        last_rd = cyc;
        rd_total++;
      end
      if (byte_valid && !prev_valid) begin
        n_vec++;
        if (cyc - last_rd != L + 1) begin
          n_err++;
          $display("FAIL valid_latency: got %0d expected %0d", cyc - last_rd, L + 1);
        end
      end
      if (prev_valid && !prev_ready) begin
        n_vec++;
        if (byte_valid !== 1'b1 || byte_out !== prev_byte || byte_last !== prev_last) begin
          n_err++;
          $display("FAIL hold: got v=%b b=%h l=%b expected v=1 b=%h l=%b",
                   byte_valid, byte_out, byte_last, prev_byte, prev_last);
        end
      end
      if (byte_valid && byte_ready) begin
        accept_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL byte_extra: got %h expected no transfer", byte_out);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({byte_last, byte_out} !== e) begin
            n_err++;
            $display("FAIL byte: got last=%b byte=%h expected last=%b byte=%h",
                     byte_last, byte_out, e[8], e[7:0]);
          end
          pend_done = e[8];
        end
      end
      prev_valid = byte_valid;
      prev_ready = byte_ready;
      prev_byte  = byte_out;
      prev_last  = byte_last;
    end
  end

  typedef struct {
    logic [31:0] word;
    logic [7:0]  ready_pat;
    int          exp_ws;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int k;
    vecs[0] = '{32'hA1B2C3D4, 8'hFF,        1};
    vecs[1] = '{32'h11223344, 8'b1011_0100, 2};
    vecs[2] = '{32'h00FF00FF, 8'h55,        3};
    vecs[3] = '{32'hFFFFFFFF, 8'h01,        4};
    vecs[4] = '{32'h80000001, 8'hAA,        5};

    // Reset values
    s_axi_aresetn = 1'b0;
    tick(3);
    chk("rst_rd_en",      {31'b0, fifo_rd_en}, 32'h0);
    chk("rst_byte_valid", {31'b0, byte_valid}, 32'h0);
    chk("rst_byte_last",  {31'b0, byte_last},  32'h0);
    chk("rst_word_done",  {31'b0, word_done},  32'h0);
    chk("rst_busy",       {31'b0, busy},       32'h0);
    chk("rst_byte_out",   {24'b0, byte_out},   32'h0);
    chk("rst_words_sent", {28'b0, words_sent}, 32'h0);
    s_axi_aresetn = 1'b1;
    tick(2);

    // Single-word vectors under different backpressure patterns
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_word(vecs[i].word);
      wait_words(1, vecs[i].ready_pat, 200, "vec_word");
      tick(1);
      chk("vec_words_sent", {28'b0, words_sent}, vecs[i].exp_ws);
      chk("vec_busy",       {31'b0, busy}, 32'h0);
      chk("vec_empty",      {31'b0, fifo_empty}, 32'h1);
    end

    // Back-to-back words with byte_ready tied high
    byte_ready = 1'b1;
    push_word(32'h01020304);
    push_word(32'h05060708);
    wait_words(2, 8'hFF, 100, "b2b");
    chk("b2b_spacing",    last_rd - prev_rd, L + 6);
    chk("b2b_words_sent", {28'b0, words_sent}, 32'h7);
    chk("b2b_empty",      {31'b0, fifo_empty}, 32'h1);

    // Enable dropped one cycle after the pop
    base = rd_total;
    push_word(32'h0A0B0C0D);
    push_word(32'h1A1B1C1D);
    k = 0;
    while (!fifo_rd_en && k < 20) begin
      tick(1);
      k++;
    end
    chk("en_rd_seen", {31'b0, fifo_rd_en}, 32'h1);
    tick(1);
    enable = 1'b0;
    wait_words(1, 8'hFF, 50, "en_first");
    tick(20);
    chk("en_no_fetch", rd_total - base, 1);
    chk("en_fifo_left", fifo_q.size(), 1);
    enable = 1'b1;
    wait_words(1, 8'hFF, 50, "en_second");
    chk("en_refetch", rd_total - base, 2);

    // Reset in the middle of a word
    base = accept_cnt;
    push_word(32'hDEADBEEF);
    k = 0;
    while (accept_cnt < base + 2 && k < 50) begin
      tick(1);
      k++;
    end
    chk("rstmid_two_bytes", accept_cnt - base, 2);
    s_axi_aresetn = 1'b0;
    #1;
    chk("rstmid_valid",      {31'b0, byte_valid}, 32'h0);
    chk("rstmid_busy",       {31'b0, busy},       32'h0);
    chk("rstmid_word_done",  {31'b0, word_done},  32'h0);
    chk("rstmid_words_sent", {28'b0, words_sent}, 32'h0);
    exp_q.delete();
    exp_ws = '0;
    base = accept_cnt;
    tick(2);
    s_axi_aresetn = 1'b1;
    tick(10);
    chk("rstmid_no_stray", accept_cnt - base, 0);
    push_word(32'hCAFE0123);
    wait_words(1, 8'hFF, 50, "rstmid_next");
    tick(1);
    chk("rstmid_next_ws", {28'b0, words_sent}, 32'h1);

    // Counter wrap with a 4-bit counter
    enable = 1'b0;
    s_axi_aresetn = 1'b0;
    exp_ws = '0;
    tick(2);
    s_axi_aresetn = 1'b1;
    for (int i = 0; i < 17; i++) push_word(32'h10203040 + i);
    enable = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      wait_words(1, 8'hFF, 50, "wrap_word");
      if (i == 15) chk("wrap_15", {28'b0, words_sent}, 32'hF);
      if (i == 16) chk("wrap_16", {28'b0, words_sent}, 32'h0);
      if (i == 17) chk("wrap_17", {28'b0, words_sent}, 32'h1);
    end
    tick(3);
    chk("end_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tx_fifo_serializer.md
Name: tx_fifo_serializer

Overview:
- Read side of the transmit word FIFO. The AXI-lite wrapper pushes 32-bit words into that FIFO.
- This block pops one word at a time and splits it into four bytes, MSB first. It presents them to the LED modulator over a valid/ready byte handshake.
- It returns a one-cycle word_done pulse, which is wired to the wrapper's fifo_wr_success so the wrapper re-arms its next FIFO write.
- It sits between the FIFO read port and the modulator byte input, in the AXI clock domain.

Parameters:
- FIFO_RD_LATENCY, 1, cycles from the FIFO sampling fifo_rd_en high to fifo_dout being valid. Legal values are 1 or 2.
- CNT_WIDTH, 16, width of the words_sent counter.

Ports:
- s_axi_aclk  input  1  clock; all logic on the rising edge.
- s_axi_aresetn  input  1  asynchronous, active-low reset.
- enable  input  1  allows new words to be fetched.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop strobe; registered, one cycle per word.
- fifo_dout  input  32  FIFO read data.
- byte_out  output  8  current byte to the modulator.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  modulator accepts the byte.
- byte_last  output  1  high with the 4th byte (bits 7:0) of a word.
- word_done  output  1  one-cycle pulse after the 4th byte is accepted.
- busy  output  1  high whenever state is not IDLE.
- words_sent  output  CNT_WIDTH  count of completed words; wraps.

Behaviour:
- Reset (async assert, sync release) sets:
  - state to IDLE
  - fifo_rd_en, byte_valid, byte_last, word_done, busy to 0
  - byte_out to 0x00, words_sent to 0
  - shift register to 0, byte index to 0, latency counter to 0.
- State machine: IDLE, READ, WAIT, SEND.
  - IDLE: if enable=1 and fifo_empty=0 at a clock edge, go to READ. Otherwise stay.
  - READ: lasts exactly one cycle with fifo_rd_en=1, then go to WAIT.
  - WAIT: lasts FIFO_RD_LATENCY cycles with fifo_rd_en=0. On the edge ending the last WAIT cycle, capture fifo_dout into the shift register. At the same edge, load byte_out=fifo_dout[31:24], set byte_valid=1, byte index=0, and go to SEND.
  - SEND: a byte transfers on an edge where byte_valid=1 and byte_ready=1.
    - Transfers 1 to 3: byte_out takes the next byte in order [23:16], [15:8], [7:0]; byte_valid stays 1.
    - byte_last=1 exactly while the [7:0] byte is presented.
    - Transfer 4: byte_valid=0, byte_last=0, word_done=1 for one cycle, words_sent+1, go to IDLE.
- Latency: byte_valid rises FIFO_RD_LATENCY+1 cycles after the cycle in which fifo_rd_en is high.
- Minimum spacing between two fifo_rd_en pulses is FIFO_RD_LATENCY+6 cycles when byte_ready is tied high. That is READ(1) + WAIT(L) + SEND(4) + IDLE(1).
- Handshake: while byte_valid=1 and byte_ready=0, byte_out and byte_last hold stable. byte_valid never drops before acceptance.
- fifo_rd_en is only asserted from IDLE with fifo_empty=0, so the block never pops an empty FIFO.
- enable deasserted mid-word (READ, WAIT or SEND): the current word still completes fully. No further fetch happens while enable=0.
- fifo_empty rising during WAIT or SEND: ignored; the word already popped is sent in full.
- words_sent wraps from all-ones to 0 with no flag.
- Reset asserted mid-word: the partial word is discarded, no word_done is issued, and outputs return to reset values immediately.
- word_done and fifo_rd_en are never high in the same cycle.
- busy=1 in READ, WAIT and SEND.

Test Plan:
- Single word, byte_ready=1, FIFO_RD_LATENCY=1.
  - Stimulus: FIFO holds 0xA1B2C3D4; enable=1.
  - Required: fifo_rd_en high for 1 cycle. byte_valid rises 2 cycles later. Bytes A1, B2, C3, D4 on consecutive cycles, with byte_last only on D4. word_done pulses once; words_sent=1; busy returns to 0.
- Backpressure.
  - Stimulus: word 0x11223344; byte_ready toggles 0,0,1,0,1,1,0,1.
  - Required: byte_out holds each byte while byte_ready=0. Sequence 11, 22, 33, 44 with no byte lost or repeated; word_done appears only after 44 is accepted.
- Back-to-back words.
  - Stimulus: FIFO holds 0x01020304 and 0x05060708; byte_ready=1.
  - Required: 8 bytes in order 01 through 08. fifo_rd_en pulses are spaced exactly 7 cycles apart. words_sent=2 and fifo_empty=1 at the end.
- Enable drop.
  - Stimulus: enable goes to 0 one cycle after fifo_rd_en, with 2 words queued.
  - Required: the first word completes with word_done. No second fifo_rd_en while enable=0. The second word starts after enable=1.
- Reset mid-word.
  - Stimulus: assert s_axi_aresetn=0 after byte 2 of 0xDEADBEEF.
  - Required: byte_valid, busy, word_done and words_sent go to 0 immediately. No EF byte is emitted after release. The next word is sent cleanly.
- Wrap.
  - Stimulus: CNT_WIDTH=4; send 17 words.
  - Required: words_sent reads 0xF after the 15th word, 0x0 after the 16th, and 0x1 after the 17th.
